// File: rtl/pong_move_scheduler.sv
// rtl/pong_move_scheduler.sv - paddle-button one-shot/auto-repeat channels feeding a round-robin move channel
//
// Build option: define AUTO_REPEAT_EN to build the hold/repeat counters and the
// REPEAT state. When it is undefined each button is a plain one-shot and the
// HOLD_CYCLES/REPEAT_CYCLES/CNT_W parameters have no effect.
//
// Ports:
//   CLOCK      sole clock, rising edge
//   Reset      synchronous active-low reset
//   Buttons    pre-debounced buttons: 0 P1Up, 1 P1Down, 2 P2Up, 3 P2Down
//   MoveReady  game logic accepts the presented command
//   MoveValid  a command is presented on MoveCode
//   MoveCode   index of the granted button
//   Pending    per-button request awaiting grant
module pong_move_scheduler #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic [3:0] Buttons,
  input  logic       MoveReady,
  output logic       MoveValid,
  output logic [1:0] MoveCode,
  output logic [3:0] Pending
);

`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } chan_state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } chan_state_e;

  logic unused_cfg;
  assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES, CNT_W};
`endif

  chan_state_e chan_q [4];
  chan_state_e chan_d [4];

  logic [3:0] prev_q, prev_d;
  logic [3:0] pend_q, pend_d;
  logic       valid_q, valid_d;
  logic [1:0] code_q, code_d;
  logic [1:0] ptr_q, ptr_d;

  logic [3:0] req;
  logic [3:0] conflict;
  logic [3:0] clr;
  logic [3:0] elig;
  logic       hs;
  logic       load;
  logic       found;
  logic [1:0] pick;

  // Both buttons of one player held together cancel that player's channels.
  assign conflict = {{2{Buttons[3] & Buttons[2]}}, {2{Buttons[1] & Buttons[0]}}};
  assign prev_d   = Buttons;

  // Per-button channel FSMs
  always_comb begin
    req = '0;
    for (int i = 0; i < 4; i++) begin
      chan_d[i] = chan_q[i];
`ifdef AUTO_REPEAT_EN
      cnt_d[i] = cnt_q[i];
`endif
      if (conflict[i] || !Buttons[i]) begin
        chan_d[i] = ST_IDLE;
`ifdef AUTO_REPEAT_EN
        cnt_d[i] = '0;
`endif
      end else begin
        case (chan_q[i])
          ST_IDLE: begin
            // prev_q resets to all ones, so a button held through reset cannot fire
            if (!prev_q[i]) begin
              chan_d[i] = ST_HOLD;
              req[i]    = 1'b1;
`ifdef AUTO_REPEAT_EN
              cnt_d[i]  = '0;
`endif
            end
          end
`ifdef AUTO_REPEAT_EN
          ST_HOLD: begin
            if (cnt_q[i] == HOLD_LAST) begin
              chan_d[i] = ST_REPEAT;
              req[i]    = 1'b1;
              cnt_d[i]  = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (cnt_q[i] == REPEAT_LAST) begin
              req[i]   = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
`else
          ST_HOLD: chan_d[i] = ST_HOLD;
`endif
          default: chan_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Round-robin arbiter and pending bookkeeping
  always_comb begin
    hs    = valid_q & MoveReady;
    load  = !valid_q | MoveReady;
    // The button just handshaken is masked so it cannot win the same search.
    clr   = hs ? (4'b0001 << code_q) : 4'b0000;
    elig  = pend_q & ~clr;
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 1; k < 5; k++) begin
      if (!found && elig[ptr_q + 2'(k)]) begin
        found = 1'b1;
        pick  = ptr_q + 2'(k);
      end
    end

    valid_d = valid_q;
    code_d  = code_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        code_d = pick;
        ptr_d  = pick;
      end
    end

    // A new request wins over a same-cycle clear.
    pend_d = (pend_q & ~clr) | req;
  end

  always_ff @(posedge CLOCK) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) begin
        chan_q[i] <= ST_IDLE;
`ifdef AUTO_REPEAT_EN
        cnt_q[i]  <= '0;
`endif
      end
      prev_q  <= 4'b1111;
      pend_q  <= 4'b0000;
      valid_q <= 1'b0;
      code_q  <= 2'd0;
      ptr_q   <= 2'd3;
    end else begin
      for (int i = 0; i < 4; i++) begin
        chan_q[i] <= chan_d[i];
`ifdef AUTO_REPEAT_EN
        cnt_q[i]  <= cnt_d[i];
`endif
      end
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
    end
  end

  assign MoveValid = valid_q;
  assign MoveCode  = code_q;
  assign Pending   = pend_q;

endmodule

// File: tb/tb_pong_move_scheduler.sv
// tb/tb_pong_move_scheduler.sv - self-checking bench for pong_move_scheduler
module tb_pong_move_scheduler;

  localparam int H = 8;
  localparam int R = 4;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       CLOCK = 1'b0;
  logic       Reset;
  logic [3:0] Buttons;
  logic       MoveReady;
  logic       MoveValid;
  logic [1:0] MoveCode;
  logic [3:0] Pending;

  int n_checks = 0;
  int n_fail   = 0;

  pong_move_scheduler #(
    .HOLD_CYCLES  (H),
    .REPEAT_CYCLES(R),
    .CNT_W        (4)
  ) dut (
    .CLOCK    (CLOCK),
    .Reset    (Reset),
    .Buttons  (Buttons),
    .MoveReady(MoveReady),
    .MoveValid(MoveValid),
    .MoveCode (MoveCode),
    .Pending  (Pending)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model: a button's "age" is edges since its press (-1 = not armed).
  int       m_age [4];
  bit [3:0] m_prev;
  bit [3:0] m_pend;
  bit       m_valid;
  int       m_code;
  int       m_ptr;
  bit       m_was_reset;

  task automatic model_step();
    bit [3:0] req;
    bit [3:0] elig;
    bit       hs;
    bit       found;
    int       old_code;
    int       j;
    m_was_reset = !Reset;
    if (!Reset) begin
      for (int i = 0; i < 4; i++) m_age[i] = -1;
      m_prev  = 4'hF;
      m_pend  = 4'h0;
      m_valid = 1'b0;
      m_code  = 0;
      m_ptr   = 3;
    end else begin
      req = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (!Buttons[i] || Buttons[i ^ 1]) begin
          m_age[i] = -1;
        end else if (m_age[i] < 0) begin
          if (!m_prev[i]) begin
            m_age[i] = 0;
            req[i]   = 1'b1;
          end
        end else begin
          m_age[i] = m_age[i] + 1;
          if (REP_EN && m_age[i] >= H && ((m_age[i] - H) % R) == 0) req[i] = 1'b1;
        end
      end
      hs       = m_valid && MoveReady;
      old_code = m_code;
      if (!m_valid || MoveReady) begin
        elig = m_pend;
        if (hs) elig[old_code] = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          j = (m_ptr + k) % 4;
          if (!found && elig[j]) begin
            found  = 1'b1;
            m_code = j;
            m_ptr  = j;
          end
        end
        m_valid = found;
      end
      if (hs) m_pend[old_code] = 1'b0;
      m_pend = m_pend | req;
      m_prev = Buttons;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply current inputs for one edge, then compare outputs against the model.
  task automatic step(input string tag);
    model_step();
    @(posedge CLOCK);
    #1;
    check({tag, "_valid"}, int'(MoveValid), int'(m_valid));
    check({tag, "_pending"}, int'(Pending), int'(m_pend));
    if (m_valid || m_was_reset) check({tag, "_code"}, int'(MoveCode), m_code);
  endtask

  typedef struct {
    bit       rstn;
    bit [3:0] btn;
    bit       rdy;
    bit       v;
    bit [1:0] c;
    bit [3:0] p;
  } vec_t;

  vec_t tbl [33];

  initial begin
    int ncmd;
    bit exp_v;

    tbl[0]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[1]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[3]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001};
    tbl[4]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001};
    tbl[5]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001};
    tbl[6]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[7]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 2'd0, 4'b0101};
    tbl[8]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0101};
    tbl[9]  = '{1'b1, 4'b1010, 1'b0, 1'b1, 2'd2, 4'b1111};
    tbl[10] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1011};
    tbl[11] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0011};
    tbl[12] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010};
    tbl[13] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[14] = '{1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0010};
    tbl[15] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010};
    tbl[16] = '{1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010};
    tbl[17] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010};
    tbl[18] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010};
    tbl[19] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010};
    tbl[20] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010};
    tbl[21] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[22] = '{1'b1, 4'b0111, 1'b1, 1'b0, 2'd0, 4'b0100};
    tbl[23] = '{1'b1, 4'b0111, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[24] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[25] = '{1'b1, 4'b1010, 1'b0, 1'b0, 2'd0, 4'b1010};
    tbl[26] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1010};
    tbl[27] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[28] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[29] = '{1'b1, 4'b0101, 1'b0, 1'b0, 2'd0, 4'b0101};
    tbl[30] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0101};
    tbl[31] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[32] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};

    Reset     = 1'b0;
    Buttons   = 4'b0000;
    MoveReady = 1'b0;

    // Directed vectors
    for (int n = 0; n < 33; n++) begin
      Reset     = tbl[n].rstn;
      Buttons   = tbl[n].btn;
      MoveReady = tbl[n].rdy;
      step($sformatf("model_row%0d", n));
      check($sformatf("row%0d_valid", n), int'(MoveValid), int'(tbl[n].v));
      check($sformatf("row%0d_pending", n), int'(Pending), int'(tbl[n].p));
      if (tbl[n].v || !tbl[n].rstn)
        check($sformatf("row%0d_code", n), int'(MoveCode), int'(tbl[n].c));
    end

    // Hold-to-repeat: button 2 held for 20 edges, MoveReady tied high
    Reset = 1'b0; Buttons = 4'b0000; MoveReady = 1'b1;
    step("rep_rst");
    Reset = 1'b1;
    step("rep_idle");
    ncmd    = 0;
    Buttons = 4'b0100;
    for (int t = 0; t < 26; t++) begin
      if (t == 20) Buttons = 4'b0000;
      step($sformatf("rep_t%0d", t));
      exp_v = (t == 1) || (REP_EN && (t == 9 || t == 13 || t == 17));
      check($sformatf("rep_valid_t%0d", t), int'(MoveValid), int'(exp_v));
      if (MoveValid) begin
        ncmd++;
        check($sformatf("rep_code_t%0d", t), int'(MoveCode), 2);
      end
    end
    check("rep_cmd_count", ncmd, REP_EN ? 4 : 1);

    // Randomized stimulus against the model
    Reset = 1'b0; Buttons = 4'b0000; MoveReady = 1'b0;
    step("rnd_rst");
    for (int n = 0; n < 1500; n++) begin
      Reset = ($urandom_range(0, 199) != 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 11) == 0) Buttons[b] = ~Buttons[b];
      MoveReady = ($urandom_range(0, 3) != 0);
      step($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
